// File: rtl/traffic_seg_pkg.sv
// rtl/traffic_seg_pkg.sv - 7-segment pattern and BCD code constants shared by display encoder and capture
package traffic_seg_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

endpackage

// File: rtl/seg2bcd.sv
// rtl/seg2bcd.sv - combinational 7-segment pattern to BCD decoder with blank/error flags
module seg2bcd
  import traffic_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       is_blank,
  output logic       is_err
);

  always_comb begin
    bcd      = BCD_ERR;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        bcd      = BCD_BLANK;
        is_blank = 1'b1;
      end
      default:   is_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - debounced capture of a multiplexed 7-segment bus into per-digit BCD with frame events
module seg_scan_capture
  import traffic_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam int              SW      = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

  logic [SW-1:0]         sample;
  logic [SW-1:0]         prev_q;
  logic [CNT_W-1:0]      run_q;
  logic [CNT_W-1:0]      run_d;
  logic                  committed_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic                  legal;
  logic                  same;
  logic                  commit;
  logic                  mask_full;
  logic [3:0]            dec_bcd;
  logic                  dec_blank;
  logic                  dec_err;

  seg2bcd u_seg2bcd (
    .seg      (seg_in),
    .bcd      (dec_bcd),
    .is_blank (dec_blank),
    .is_err   (dec_err)
  );

  assign sample    = {dig_sel, seg_in};
  assign legal     = en && $onehot(dig_sel);
  assign same      = (sample == prev_q);
  assign mask_full = &mask_q;

  always_comb begin
    run_d = '0;
    if (legal) begin
      if (!same)
        run_d = CNT_W'(1);
      else if (run_q >= RUN_MAX)
        run_d = RUN_MAX;
      else
        run_d = run_q + CNT_W'(1);
    end
  end

  // Saturating counter plus the committed flag yields exactly one commit per stable run.
  assign commit = legal && (run_d == RUN_MAX) && !committed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      run_q       <= '0;
      committed_q <= 1'b0;
      mask_q      <= '0;
      bcd_out     <= {NUM_DIGITS{BCD_BLANK}};
      blank       <= '1;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      prev_q      <= sample;
      run_q       <= run_d;
      frame_valid <= mask_full;

      if (!legal || !same)
        committed_q <= 1'b0;
      else if (commit)
        committed_q <= 1'b1;

      // A full mask lives for one cycle; a commit landing then starts the next frame.
      if (mask_full)
        frame_err <= |digit_err;
      mask_q <= (mask_full ? '0 : mask_q) | (commit ? dig_sel : '0);

      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (dig_sel[i]) begin
            bcd_out[4*i +: 4] <= dec_bcd;
            blank[i]          <= dec_blank;
            digit_err[i]      <= dec_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed table-driven bench for seg_scan_capture
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] dig_sel;
  logic [6:0] seg_in;
  logic [7:0] bcd_out;
  logic [1:0] blank;
  logic [1:0] digit_err;
  logic       frame_valid;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int fv_base;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t vecs [15];

  seg_scan_capture #(
    .NUM_DIGITS    (2),
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dig_sel     (dig_sel),
    .seg_in      (seg_in),
    .bcd_out     (bcd_out),
    .blank       (blank),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_valid === 1'b1) fv_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; dig_sel = 2'b00; seg_in = 7'h00;
    step(2);
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic hold(input logic [1:0] sel, input logic [6:0] s, input int n);
    dig_sel = sel; seg_in = s;
    step(n);
  endtask

  initial begin
    logic [3:0] prev_bcd;

    vecs[0]  = '{7'h3F, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{7'h06, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{7'h5B, 4'd2, 1'b0, 1'b0};
    vecs[3]  = '{7'h4F, 4'd3, 1'b0, 1'b0};
    vecs[4]  = '{7'h66, 4'd4, 1'b0, 1'b0};
    vecs[5]  = '{7'h6D, 4'd5, 1'b0, 1'b0};
    vecs[6]  = '{7'h7D, 4'd6, 1'b0, 1'b0};
    vecs[7]  = '{7'h07, 4'd7, 1'b0, 1'b0};
    vecs[8]  = '{7'h7F, 4'd8, 1'b0, 1'b0};
    vecs[9]  = '{7'h6F, 4'd9, 1'b0, 1'b0};
    vecs[10] = '{7'h00, 4'hF, 1'b1, 1'b0};
    vecs[11] = '{7'h49, 4'hE, 1'b0, 1'b1};
    vecs[12] = '{7'h06, 4'd1, 1'b0, 1'b0};
    vecs[13] = '{7'h7E, 4'hE, 1'b0, 1'b1};
    vecs[14] = '{7'h01, 4'hE, 1'b0, 1'b1};

    do_reset();
    chk("reset_bcd",   bcd_out,     8'hFF);
    chk("reset_blank", blank,       2'b11);
    chk("reset_err",   digit_err,   2'b00);
    chk("reset_fv",    frame_valid, 1'b0);
    chk("reset_ferr",  frame_err,   1'b0);

    // Decode table on digit 0; value must still be old after 3 cycles, new after 4.
    prev_bcd = 4'hF;
    fv_base  = fv_cnt;
    for (int i = 0; i < 15; i++) begin
      hold(2'b01, vecs[i].seg, 3);
      chk($sformatf("vec%0d_early", i), bcd_out[3:0], prev_bcd);
      step(1);
      chk($sformatf("vec%0d_bcd", i),   bcd_out[3:0], vecs[i].bcd);
      chk($sformatf("vec%0d_blank", i), blank[0],     vecs[i].blank);
      chk($sformatf("vec%0d_err", i),   digit_err[0], vecs[i].err);
      chk($sformatf("vec%0d_d1", i),    bcd_out[7:4], 4'hF);
      prev_bcd = vecs[i].bcd;
    end
    step(1);
    chk("vec_no_frame", fv_cnt - fv_base, 0);

    // Two-digit frame.
    do_reset();
    fv_base = fv_cnt;
    hold(2'b01, 7'h5B, 4);
    hold(2'b10, 7'h07, 4);
    chk("f1_bcd",   bcd_out,     8'h72);
    chk("f1_blank", blank,       2'b00);
    chk("f1_err",   digit_err,   2'b00);
    chk("f1_fv_lo", frame_valid, 1'b0);
    step(1);
    chk("f1_fv_hi", frame_valid, 1'b1);
    chk("f1_ferr",  frame_err,   1'b0);
    step(1);
    chk("f1_fv_end", frame_valid, 1'b0);
    step(3);
    chk("f1_fv_once", fv_cnt - fv_base, 1);

    // Change before commit restarts the count.
    do_reset();
    hold(2'b01, 7'h6D, 3);
    chk("rs_none", bcd_out[3:0], 4'hF);
    hold(2'b01, 7'h66, 3);
    chk("rs_early", bcd_out[3:0], 4'hF);
    step(1);
    chk("rs_commit", bcd_out[3:0], 4'd4);

    // Illegal selects and en=0 never commit.
    do_reset();
    fv_base = fv_cnt;
    hold(2'b11, 7'h7F, 10);
    chk("ill11_bcd",   bcd_out, 8'hFF);
    chk("ill11_blank", blank,   2'b11);
    hold(2'b00, 7'h7F, 10);
    chk("ill00_bcd",   bcd_out, 8'hFF);
    chk("ill00_blank", blank,   2'b11);
    en = 1'b0;
    hold(2'b01, 7'h7F, 10);
    chk("en0_bcd", bcd_out, 8'hFF);
    en = 1'b1;
    step(3);
    chk("en1_early", bcd_out[3:0], 4'hF);
    step(1);
    chk("en1_commit", bcd_out[3:0], 4'd8);
    step(1);
    chk("ill_no_frame", fv_cnt - fv_base, 0);

    // Error and blank digits in one frame.
    do_reset();
    hold(2'b01, 7'h49, 4);
    hold(2'b10, 7'h00, 4);
    chk("eb_bcd",   bcd_out,   8'hFE);
    chk("eb_err",   digit_err, 2'b01);
    chk("eb_blank", blank,     2'b10);
    step(1);
    chk("eb_fv",   frame_valid, 1'b1);
    chk("eb_ferr", frame_err,   1'b1);
    step(3);
    chk("eb_ferr_hold", frame_err, 1'b1);

    // Long hold: single commit, no frame.
    do_reset();
    fv_base = fv_cnt;
    hold(2'b01, 7'h3F, 20);
    chk("long_bcd", bcd_out, 8'hF0);
    step(1);
    chk("long_no_frame", fv_cnt - fv_base, 0);

    // Reset discards a partial frame.
    do_reset();
    hold(2'b01, 7'h3F, 4);
    chk("rf_d0", bcd_out, 8'hF0);
    do_reset();
    chk("rf_reset_bcd", bcd_out, 8'hFF);
    chk("rf_reset_blank", blank, 2'b11);
    fv_base = fv_cnt;
    hold(2'b10, 7'h07, 4);
    chk("rf_d1", bcd_out, 8'h7F);
    step(3);
    chk("rf_no_frame", fv_cnt - fv_base, 0);
    hold(2'b01, 7'h3F, 4);
    chk("rf_d0_again", bcd_out, 8'h70);
    step(1);
    chk("rf_fv", frame_valid, 1'b1);
    step(2);
    chk("rf_frame_once", fv_cnt - fv_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
